// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and
// counter sizing helper.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to count 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: D = A - B - Bin, Bout = borrow out.
// Purely combinational, zero latency, no flow control.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first: WIDTH+1 cycles from start to done.
// start is only accepted in IDLE; requests while busy or done are dropped, not queued.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] diff_shift;

  full_subtractor u_fs (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Bin  (br),
    .D    (d_bit),
    .Bout (br_nxt)
  );

  // Result bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign diff_shift = d_bit;
    end else begin : g_wn
      assign diff_shift = {d_bit, diff[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_nxt;
          diff <= diff_shift;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            bout  <= br_nxt;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes diff = a − b, LSB first, one bit per clock.
- Built from a single full-subtractor cell plus a borrow flip-flop. It is the subtract counterpart of the team's NOR-based half/full adder cells.
- Sits behind a start/busy/done handshake, so a sequencing FSM or a lab top-level with switches and LEDs can drive it.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse; diff and bout are valid from this cycle.
- diff  output  WIDTH  a − b modulo 2^WIDTH.
- bout  output  1  final borrow out; 1 exactly when a < b (unsigned).

Behaviour:
- Reset: one clk edge with rst=1 forces state=IDLE, busy=0, done=0, diff=0, bout=0, bit counter=0, borrow register=0, operand shift registers=0.
- Reset mid-operation aborts the subtraction with no done pulse. rst has priority over start.
- FSM states:
  - IDLE: busy=0, done=0; diff and bout hold their last results. start=1 → capture a and b into shift regs, clear borrow, clear counter, go to SHIFT.
  - SHIFT: busy=1. Each cycle the full-subtractor cell consumes the LSB of each shift reg plus the borrow register:
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
    - d shifts into diff from the MSB side; the operand regs shift right; the counter increments.
    - When counter == WIDTH−1, the last bit is processed and the FSM goes to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. bout = final borrow, diff complete. Next state is IDLE.
- Timing: start accepted at edge t → busy high from t+1 through t+WIDTH → done high in cycle t+WIDTH+1. Total latency is WIDTH+1 cycles.
- start in SHIFT or DONE is ignored; there is no queuing. a and b may change freely after capture without affecting the result.
- start held high continuously → a new subtraction is accepted on the first IDLE cycle after DONE. Back-to-back throughput is one result per WIDTH+2 cycles.
- diff is updated bit by bit during SHIFT; its value is only meaningful from done onward.
- Arithmetic is unsigned modulo 2^WIDTH, with no overflow flag. Signed users interpret diff as two's complement.
- WIDTH=1: one SHIFT cycle, done at t+2.

Decomposition:
- Shared package sub_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t
  - localparam for the counter width, $clog2(WIDTH+1)
- Sub-module full_subtractor (combinational; ports A, B, Bin, D, Bout), instantiated once inside serial_subtractor. It is reusable by the combinational subtractor labs.

Test Plan:
- WIDTH=8; rst high 2 cycles, then low → busy=0, done=0, diff=0x00, bout=0. Start with a=5, b=3 → done exactly 9 cycles after the start edge, diff=0x02, bout=0, busy high for 8 cycles.
- a=3, b=5 → diff=0xFE, bout=1. Then a=0x00, b=0xFF → diff=0x01, bout=1. Then a=0xFF, b=0xFF → diff=0x00, bout=0.
- Start a=0x80, b=0x01; pulse start again with a=0x10, b=0x10 in the 3rd SHIFT cycle → second request ignored, result diff=0x7F, bout=0, only one done pulse.
- Start a=0xAA, b=0x55; assert rst in the 4th SHIFT cycle → next cycle busy=0, diff=0x00, bout=0, no done pulse. A following start with a=0xAA, b=0x55 → diff=0x55, bout=0.
- Hold start=1 for 30 cycles with a=9, b=4 → done pulses at start+9 and start+19, diff=0x05, bout=0 each time. Hold periods are checked against the WIDTH+2 throughput.
- Exhaustive check with WIDTH=4: all 256 a/b pairs versus the reference model (a−b) mod 16 and a<b. Repeat with WIDTH=1 over 4 pairs, expecting done at t+2.
